// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths, zero constants and round-robin requester encodings for the
// GPR writeback arbiter.
package gpr_wb_arbiter_pkg;

    localparam int unsigned DataBus_WIDTH    = 64;
    localparam int unsigned RegAddrBus_WIDTH = 5;

    localparam logic [RegAddrBus_WIDTH-1:0] GPR0    = '0;
    localparam logic [DataBus_WIDTH-1:0]    DW_ZERO = '0;

    // Identity of the requester granted most recently.
    typedef enum logic {
        WBA_REQ_EXU = 1'b0,
        WBA_REQ_LSU = 1'b1
    } wba_req_e;

endpackage

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR, set when decode issues a
// producer and cleared when the register file commits it. Register 0 is never
// busy.
module gpr_scoreboard #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_GPR = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    output logic              rs1_busy_o,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs2_busy_o,
    output logic              any_busy_o
);

    logic [NUM_GPR-1:0] busy_q;
    logic [NUM_GPR-1:0] busy_d;

    // Next busy vector: clear on commit, then set on issue so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 1; i < NUM_GPR; i++) begin
            if (clr_i && (clr_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_i && (set_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Combinational lookups for the two decode source operands.
    always_comb begin
        rs1_busy_o = 1'b0;
        rs2_busy_o = 1'b0;
        for (int unsigned i = 1; i < NUM_GPR; i++) begin
            if (rs1_addr_i == ADDR_W'(i)) begin
                rs1_busy_o = busy_q[i];
            end
            if (rs2_addr_i == ADDR_W'(i)) begin
                rs2_busy_o = busy_q[i];
            end
        end
    end

    assign any_busy_o = |busy_q;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the GPR write port between EXU and LSU
// writebacks, with a registered write stage and a RAW scoreboard.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = DataBus_WIDTH,
    parameter int unsigned ADDR_W  = RegAddrBus_WIDTH,
    parameter int unsigned NUM_GPR = 32
) (
    input  logic              wba_clk_i,
    input  logic              wba_rst_i,

    input  logic              exu_wb_valid_i,
    output logic              exu_wb_ready_o,
    input  logic [ADDR_W-1:0] exu_wb_addr_i,
    input  logic [DATA_W-1:0] exu_wb_data_i,

    input  logic              lsu_wb_valid_i,
    output logic              lsu_wb_ready_o,
    input  logic [ADDR_W-1:0] lsu_wb_addr_i,
    input  logic [DATA_W-1:0] lsu_wb_data_i,

    output logic              reg_wen_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,

    input  logic              sb_set_i,
    input  logic [ADDR_W-1:0] sb_set_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    output logic              rs1_busy_o,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs2_busy_o,
    output logic              sb_any_busy_o
);

    wba_req_e          rr_q;
    wba_req_e          rr_d;
    logic              gnt_exu;
    logic              gnt_lsu;
    logic              wen_q;
    logic              wen_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;

    // Grant from valids and the last-granted pointer only; nothing granted in reset.
    always_comb begin
        gnt_exu = 1'b0;
        gnt_lsu = 1'b0;
        if (!wba_rst_i) begin
            if (exu_wb_valid_i && lsu_wb_valid_i) begin
                if (rr_q == WBA_REQ_LSU) begin
                    gnt_exu = 1'b1;
                end else begin
                    gnt_lsu = 1'b1;
                end
            end else begin
                gnt_exu = exu_wb_valid_i;
                gnt_lsu = lsu_wb_valid_i;
            end
        end
    end

    assign exu_wb_ready_o = gnt_exu;
    assign lsu_wb_ready_o = gnt_lsu;

    // Load the write stage from the granted requester and advance the pointer on a transfer.
    always_comb begin
        rr_d    = rr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt_exu) begin
            rr_d    = WBA_REQ_EXU;
            wen_d   = (exu_wb_addr_i != '0);
            waddr_d = exu_wb_addr_i;
            wdata_d = exu_wb_data_i;
        end else if (gnt_lsu) begin
            rr_d    = WBA_REQ_LSU;
            wen_d   = (lsu_wb_addr_i != '0);
            waddr_d = lsu_wb_addr_i;
            wdata_d = lsu_wb_data_i;
        end
    end

    // Pointer and output-stage registers with synchronous reset.
    always_ff @(posedge wba_clk_i) begin
        if (wba_rst_i) begin
            rr_q    <= WBA_REQ_LSU;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // A write accepted just before reset is suppressed in the reset cycle so
    // the register file never commits it at the reset edge.
    assign reg_wen_o   = wen_q & ~wba_rst_i;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = wdata_q;

    gpr_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_GPR (NUM_GPR)
    ) u_scoreboard (
        .clk_i      (wba_clk_i),
        .rst_i      (wba_rst_i),
        .set_i      (sb_set_i),
        .set_addr_i (sb_set_addr_i),
        .clr_i      (reg_wen_o),
        .clr_addr_i (reg_waddr_o),
        .rs1_addr_i (rs1_addr_i),
        .rs1_busy_o (rs1_busy_o),
        .rs2_addr_i (rs2_addr_i),
        .rs2_busy_o (rs2_busy_o),
        .any_busy_o (sb_any_busy_o)
    );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_gpr_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          exu_v, lsu_v, sb_set;
    logic [AW-1:0] exu_a, lsu_a, sb_a, rs1_a, rs2_a;
    logic [DW-1:0] exu_d, lsu_d;
    logic          exu_rdy, lsu_rdy, wen, rs1_busy, rs2_busy, any_busy;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    gpr_wb_arbiter #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_GPR (NG)
    ) dut (
        .wba_clk_i      (clk),
        .wba_rst_i      (rst),
        .exu_wb_valid_i (exu_v),
        .exu_wb_ready_o (exu_rdy),
        .exu_wb_addr_i  (exu_a),
        .exu_wb_data_i  (exu_d),
        .lsu_wb_valid_i (lsu_v),
        .lsu_wb_ready_o (lsu_rdy),
        .lsu_wb_addr_i  (lsu_a),
        .lsu_wb_data_i  (lsu_d),
        .reg_wen_o      (wen),
        .reg_waddr_o    (waddr),
        .reg_wdata_o    (wdata),
        .sb_set_i       (sb_set),
        .sb_set_addr_i  (sb_a),
        .rs1_addr_i     (rs1_a),
        .rs1_busy_o     (rs1_busy),
        .rs2_addr_i     (rs2_a),
        .rs2_busy_o     (rs2_busy),
        .sb_any_busy_o  (any_busy)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: writes in flight, per-register pending flags, last winner.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           inflight[$];
    bit [NG-1:0]   m_busy;
    int            m_last;      // 0 = EXU, 1 = LSU
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_exu_acc, m_lsu_acc;

    // -1 nobody, 0 EXU, 1 LSU.
    function automatic int winner(logic r, logic ev, logic lv, int last);
        if (r) return -1;
        if (ev && lv) return (last == 1) ? 0 : 1;
        if (ev) return 0;
        if (lv) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int  w;
        wr_t c;
        wr_t n;
        w = winner(rst, exu_v, lsu_v, m_last);
        m_exu_acc = (w == 0);
        m_lsu_acc = (w == 1);
        if (rst) begin
            inflight.delete();
            m_busy  = '0;
            m_last  = 1;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            if (inflight.size() > 0) begin
                c = inflight.pop_front();
                if (c.a != 0) m_busy[c.a] = 1'b0;
            end
            if (sb_set && sb_a != 0) m_busy[sb_a] = 1'b1;
            if (w >= 0) begin
                n.a = (w == 0) ? exu_a : lsu_a;
                n.d = (w == 0) ? exu_d : lsu_d;
                inflight.push_back(n);
                m_last  = w;
                m_waddr = n.a;
                m_wdata = n.d;
            end
        end
    end

    always @(negedge clk) begin
        int   w;
        logic exp_wen;
        if (chk_en) begin
            w = winner(rst, exu_v, lsu_v, m_last);
            exp_wen = 1'b0;
            if (!rst && inflight.size() > 0) exp_wen = (inflight[0].a != 0);
            chk("exu_ready", exu_rdy, w == 0);
            chk("lsu_ready", lsu_rdy, w == 1);
            chk("reg_wen", wen, exp_wen);
            chk("reg_waddr", waddr, m_waddr);
            chk("reg_wdata", wdata, m_wdata);
            chk("rs1_busy", rs1_busy, (rs1_a == 0) ? 1'b0 : m_busy[rs1_a]);
            chk("rs2_busy", rs2_busy, (rs2_a == 0) ? 1'b0 : m_busy[rs2_a]);
            chk("any_busy", any_busy, |m_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; exu_v = 1'b0; lsu_v = 1'b0; sb_set = 1'b0;
        exu_a = '0; lsu_a = '0; sb_a = '0; rs1_a = '0; rs2_a = '0;
        exu_d = '0; lsu_d = '0;

        // Reset then idle.
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NG; i++) begin
            rs1_a = AW'(i);
            @(negedge clk);
            chk("idle_rs1_busy", rs1_busy, 0);
            chk("idle_wen", wen, 0);
            chk("idle_any_busy", any_busy, 0);
            tick();
        end

        // Single EXU write.
        exu_v = 1'b1; exu_a = 5; exu_d = 64'h1234;
        @(negedge clk); chk("single_ready", exu_rdy, 1);
        tick(); exu_v = 1'b0;
        @(negedge clk);
        chk("single_wen", wen, 1);
        chk("single_waddr", waddr, 5);
        chk("single_wdata", wdata, 64'h1234);
        tick();
        @(negedge clk); chk("single_wen_after", wen, 0);
        tick();

        // Contention from a fresh reset: EXU first, then alternate.
        do_reset(2);
        exu_v = 1'b1; exu_a = 3; exu_d = 64'hA;
        lsu_v = 1'b1; lsu_a = 4; lsu_d = 64'hB;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("cont_exu_ready", exu_rdy, (k % 2) == 0);
            chk("cont_lsu_ready", lsu_rdy, (k % 2) == 1);
            if (k > 0) begin
                chk("cont_wen", wen, 1);
                chk("cont_waddr", waddr, (k % 2) ? 3 : 4);
                chk("cont_wdata", wdata, (k % 2) ? 64'hA : 64'hB);
            end
            tick();
        end
        exu_v = 1'b0; lsu_v = 1'b0;
        tick();

        // Scoreboard lifetime for x7.
        rs1_a = 7; sb_set = 1'b1; sb_a = 7;
        @(negedge clk); chk("life_c0", rs1_busy, 0);
        tick(); sb_set = 1'b0;
        @(negedge clk); chk("life_c1", rs1_busy, 1);
        tick();
        @(negedge clk); chk("life_c2", rs1_busy, 1);
        tick(); lsu_v = 1'b1; lsu_a = 7; lsu_d = 64'h77;
        @(negedge clk); chk("life_c3", rs1_busy, 1); chk("life_lsu_ready", lsu_rdy, 1);
        tick(); lsu_v = 1'b0;
        @(negedge clk); chk("life_c4_busy", rs1_busy, 1); chk("life_c4_wen", wen, 1);
        chk("life_c4_waddr", waddr, 7);
        tick();
        @(negedge clk); chk("life_c5", rs1_busy, 0);

        // Set/clear collision on x9.
        rs1_a = 9; sb_set = 1'b1; sb_a = 9;
        tick(); sb_set = 1'b0; lsu_v = 1'b1; lsu_a = 9; lsu_d = 64'h99;
        tick(); lsu_v = 1'b0; sb_set = 1'b1; sb_a = 9;
        @(negedge clk); chk("coll_wen", wen, 1); chk("coll_waddr", waddr, 9);
        tick(); sb_set = 1'b0; exu_v = 1'b1; exu_a = 9; exu_d = 64'h999;
        @(negedge clk); chk("coll_busy_kept", rs1_busy, 1);
        tick(); exu_v = 1'b0;
        tick();
        @(negedge clk); chk("coll_busy_cleared", rs1_busy, 0);

        // Write to x0.
        exu_v = 1'b1; exu_a = 0; exu_d = 64'hDEAD;
        @(negedge clk); chk("x0_ready", exu_rdy, 1);
        tick(); exu_v = 1'b0;
        @(negedge clk); chk("x0_wen", wen, 0);
        tick();

        // Reset one cycle after an accepted write.
        sb_set = 1'b1; sb_a = 12; exu_v = 1'b1; exu_a = 6; exu_d = 64'h66;
        @(negedge clk); chk("mid_ready", exu_rdy, 1);
        tick(); sb_set = 1'b0; rst = 1'b1;
        @(negedge clk); chk("mid_wen_in_reset", wen, 0); chk("mid_ready_in_reset", exu_rdy, 0);
        tick(); rst = 1'b0; exu_v = 1'b0;
        @(negedge clk); chk("mid_wen_after", wen, 0); chk("mid_any_busy", any_busy, 0);
        chk("mid_waddr", waddr, 0);
        tick();

        // Randomized traffic obeying the hold-until-ready rule.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!exu_v || m_exu_acc) begin
                exu_v = ($urandom_range(0, 9) < 6);
                exu_a = AW'($urandom_range(0, NG - 1));
                exu_d = {$urandom, $urandom};
            end
            if (!lsu_v || m_lsu_acc) begin
                lsu_v = ($urandom_range(0, 9) < 5);
                lsu_a = AW'($urandom_range(0, NG - 1));
                lsu_d = {$urandom, $urandom};
            end
            sb_set = ($urandom_range(0, 3) == 0);
            sb_a   = AW'($urandom_range(0, NG - 1));
            rs1_a  = AW'($urandom_range(0, NG - 1));
            rs2_a  = AW'($urandom_range(0, NG - 1));
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single GPR write port of the general-purpose register file between two writeback requesters: EXU (ALU/CSR results) and LSU (load data).
- Arbitrates round-robin, with a valid/ready handshake per requester.
- Drives a registered write to the register file.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards against in-flight destinations.

Parameters:
- DATA_W, 64, GPR data width; matches `DataBus_WIDTH.
- ADDR_W, 5, GPR index width; matches `RegAddrBus_WIDTH.
- NUM_GPR, 32, number of architectural registers; sets the scoreboard width.

Ports:
- wba_clk_i  in  1  clock
- wba_rst_i  in  1  reset, synchronous, active-high
- exu_wb_valid_i  in  1  EXU writeback request
- exu_wb_ready_o  out  1  EXU request accepted this cycle
- exu_wb_addr_i  in  ADDR_W  EXU destination register
- exu_wb_data_i  in  DATA_W  EXU result
- lsu_wb_valid_i  in  1  LSU writeback request
- lsu_wb_ready_o  out  1  LSU request accepted this cycle
- lsu_wb_addr_i  in  ADDR_W  LSU destination register
- lsu_wb_data_i  in  DATA_W  load data
- reg_wen_o  out  1  register file write enable
- reg_waddr_o  out  ADDR_W  register file write address
- reg_wdata_o  out  DATA_W  register file write data
- sb_set_i  in  1  decode issued an instruction that writes a destination register
- sb_set_addr_i  in  ADDR_W  that destination register
- rs1_addr_i  in  ADDR_W  scoreboard query 1
- rs1_busy_o  out  1  rs1 has a pending write
- rs2_addr_i  in  ADDR_W  scoreboard query 2
- rs2_busy_o  out  1  rs2 has a pending write
- sb_any_busy_o  out  1  OR of all scoreboard bits

Behaviour:
- Reset (clock edge with wba_rst_i=1):
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - Scoreboard all zero.
  - RR pointer = LSU, so EXU wins the first tie.
  - Reset mid-operation discards any accepted-but-uncommitted write: reg_wen_o is 0 in the following cycle and the register file sees no write.
- While wba_rst_i=1, both ready outputs are 0.
- Handshake:
  - A requester holds valid, addr and data stable until its ready is 1; transfer occurs on any edge with valid&ready.
  - ready is combinational from the valids and the RR pointer only; there is no combinational path from any input data to ready.
- Arbitration:
  - The output stage accepts one write every cycle; the arbiter never stalls both requesters.
  - Only one valid: it is granted.
  - Both valid: the requester not granted last is granted.
  - The RR pointer updates only on a transfer.
- Output stage and latency:
  - A transfer at edge E loads the output regs.
  - reg_wen_o is 1 for exactly the cycle after E; the register file commits at edge E+1.
  - If no transfer occurs at E, reg_wen_o=0 in the next cycle; waddr/wdata hold their last values.
  - A transfer with addr=0 is accepted (ready=1), but reg_wen_o stays 0.
- Scoreboard (NUM_GPR bits, bit 0 hardwired 0):
  - Set at an edge with sb_set_i=1 and sb_set_addr_i≠0.
  - Cleared at an edge with reg_wen_o=1 for bit reg_waddr_o.
  - Same bit set and cleared at the same edge: set wins, because a new producer was issued.
  - The busy bit stays 1 during the reg_wen_o cycle, since the register file's combinational read still returns the old value then.
  - rsN_busy_o = bit[rsN_addr_i], combinational; address 0 always reads 0.
- The arbiter does not check writes against the scoreboard. A writeback to a non-busy register still writes and clears nothing extra.
- Each busy bit tracks at most one outstanding producer per register; decode guarantees this by stalling on WAW using rsN_busy_o or an equivalent query.

Decomposition:
- Shared defines/package holds:
  - existing DataBus_WIDTH, RegAddrBus_WIDTH, GPR0, DW_ZERO;
  - new WBA_REQ_EXU=0 and WBA_REQ_LSU=1 encodings for the RR pointer.
- One sub-module, gpr_scoreboard: busy vector with set/clear ports, set-over-clear priority, and two combinational query ports.
- The arbiter and output register stay in the top level.

Test Plan:
- Reset then idle:
  - Assert wba_rst_i for 2 cycles, then release.
  - Required: reg_wen_o=0, rs1_busy_o=0 for all addresses, sb_any_busy_o=0.
- Single EXU write:
  - exu valid, addr=5, data=0x1234 for one cycle.
  - Required: exu_wb_ready_o=1 the same cycle; next cycle reg_wen_o=1, waddr=5, wdata=0x1234; following cycle reg_wen_o=0.
- Contention:
  - Both valid continuously: EXU addr=3/data=0xA, LSU addr=4/data=0xB.
  - Required: grants EXU, LSU, EXU… with one grant per cycle and commits alternating 3, 4.
- Scoreboard lifetime:
  - sb_set_i with addr=7; 3 cycles later LSU writes addr=7.
  - Required: rs1_busy_o(rs1_addr_i=7)=1 from the cycle after set through the reg_wen_o cycle, and 0 the cycle after.
- Set/clear collision:
  - Commit cycle for addr=9 with sb_set_i, sb_set_addr_i=9 in the same cycle.
  - Required: bit 9 remains 1 afterward.
- x0 and mid-op reset:
  - EXU writes addr=0: ready=1, reg_wen_o stays 0.
  - Separately, transfer at edge E with wba_rst_i=1 at E+1: reg_wen_o=0 and the scoreboard is cleared.
